// File: rtl/btn_led_pkg.sv
// Shared definitions for the button/LED controller.
//   MODE_*  : per-channel LED mode encoding (2 bits per channel)
//   clog2() : ceiling log2, usable in localparam expressions
package btn_led_pkg;

  localparam logic [1:0] MODE_FOLLOW = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, polarity fix, debounce counter and
// press pulse.
//   clk, rst_n : clock, async active-low reset
//   button     : raw asynchronous button pin
//   pressed    : debounced level, 1 = held
//   press      : one-cycle pulse, high in the first cycle pressed reads 1
module btn_debounce
  import btn_led_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 120000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pressed,
  output logic press
);

  localparam int unsigned     CNT_W    = (clog2(DB_CYCLES) > 0) ? clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic             RELEASED = BTN_ACTIVE_LOW;

  logic             sync_q1;
  logic             sync_q2;
  logic             level_c;
  logic [CNT_W-1:0] cnt_q;

  // Synchroniser; resets to the pin's released level so no false press appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= RELEASED;
      sync_q2 <= RELEASED;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

  assign level_c = sync_q2 ^ BTN_ACTIVE_LOW;

  // Accept a new level only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (level_c == pressed) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        pressed <= level_c;
        press   <= level_c;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_led_ctrl.sv
// Multi-channel debounced button to LED controller.
//   CLK, rst_n   : clock, async active-low reset
//   button       : raw button pins, one per channel
//   mode         : per-channel mode, channel i at [2i+1:2i]
//   EXTERNAL_LED : registered LED drive, 1 = on
//   press        : one-cycle pulse per debounced press
//   pressed      : debounced level, 1 = held
module button_led_ctrl
  import btn_led_pkg::*;
#(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned DB_CYCLES      = 120000,
  parameter int unsigned BLINK_HALF     = 3000000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     button,
  input  logic [2*N_CH-1:0]   mode,
  output logic [N_CH-1:0]     EXTERNAL_LED,
  output logic [N_CH-1:0]     press,
  output logic [N_CH-1:0]     pressed
);

  localparam int unsigned       BLINK_W    = (clog2(BLINK_HALF) > 0) ? clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;

  // Shared blink timebase so all blinking channels stay in phase.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0] ch_mode_c;
    logic       led_next_c;
    logic       toggle_q;
    logic       led_q;

    assign ch_mode_c = mode[2*g +: 2];

    btn_debounce #(
      .DB_CYCLES      (DB_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db (
      .clk     (CLK),
      .rst_n   (rst_n),
      .button  (button[g]),
      .pressed (pressed[g]),
      .press   (press[g])
    );

    // Toggle state follows presses regardless of mode, so it survives mode changes.
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) toggle_q <= 1'b0;
      else        toggle_q <= toggle_q ^ press[g];
    end

    // Next LED value by mode.
    always_comb begin
      led_next_c = 1'b0;
      case (ch_mode_c)
        MODE_FOLLOW: led_next_c = pressed[g];
        MODE_TOGGLE: led_next_c = toggle_q;
        MODE_BLINK:  led_next_c = toggle_q & blink_phase_q;
        MODE_OFF:    led_next_c = 1'b0;
        default:     led_next_c = 1'b0;
      endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) led_q <= 1'b0;
      else        led_q <= led_next_c;
    end

    assign EXTERNAL_LED[g] = led_q;
  end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Self-checking bench for button_led_ctrl (N_CH=3, DB_CYCLES=4, BLINK_HALF=8,
// active-low buttons). Expected output vectors are queued per cycle as
// stimulus is applied and compared once the DUT edge has occurred.
module tb_button_led_ctrl;

  typedef struct {
    logic [2:0] pr;
    logic [2:0] pl;
    logic [2:0] led;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] button;
  logic [5:0] mode;
  logic [2:0] led;
  logic [2:0] press;
  logic [2:0] pressed;

  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];

  button_led_ctrl #(
    .N_CH           (3),
    .DB_CYCLES      (4),
    .BLINK_HALF     (8),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK          (clk),
    .rst_n        (rst_n),
    .button       (button),
    .mode         (mode),
    .EXTERNAL_LED (led),
    .press        (press),
    .pressed      (pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Blink phase after edge k counted from reset release.
  function automatic logic ph(input int k);
    return ((k / 8) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst_n  = 1'b1;
    button = 3'b111;
    mode   = 6'b000000;
    #2 rst_n = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      e.pr = '0; e.pl = '0; e.led = '0;
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL reset c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_follow();
    exp_t e, got;
    button[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      e.pr = '0; e.pl = '0; e.led = '0;
      e.pr[0]  = (c >= 6 && c < 16);
      e.pl[0]  = (c == 6);
      e.led[0] = (c >= 7 && c < 17);
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL follow c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
      if (c == 10) button[0] = 1'b1;
    end
  endtask

  task automatic test_bounce();
    exp_t e, got;
    button[1] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      e.pr = '0; e.pl = '0; e.led = '0;
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL bounce c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
      if (c == 3) button[1] = 1'b1;
      if (c == 4) button[1] = 1'b0;
      if (c == 7) button[1] = 1'b1;
    end
  endtask

  task automatic test_toggle();
    exp_t e, got;
    mode = 6'b000100;
    for (int c = 1; c <= 42; c++) begin
      e.pr = '0; e.pl = '0; e.led = '0;
      e.pr[1]  = (c >= 8 && c < 18) || (c >= 28 && c < 38);
      e.pl[1]  = (c == 8) || (c == 28);
      e.led[1] = (c >= 10 && c < 30);
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL toggle c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
      if (c == 2)  button[1] = 1'b0;
      if (c == 12) button[1] = 1'b1;
      if (c == 22) button[1] = 1'b0;
      if (c == 32) button[1] = 1'b1;
    end
  endtask

  task automatic test_blink();
    exp_t e, got;
    int   cyc0;
    logic tog;
    cyc0      = cyc;
    mode      = 6'b100100;
    button[2] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tog = ((c - 1) >= 7 && (c - 1) < 47);
      e.pr = '0; e.pl = '0; e.led = '0;
      e.pr[2]  = (c >= 6 && c < 14) || (c >= 46 && c < 54);
      e.pl[2]  = (c == 6) || (c == 46);
      e.led[2] = tog & ph(cyc0 + c - 1);
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL blink c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
      if (c == 8)  button[2] = 1'b1;
      if (c == 40) button[2] = 1'b0;
      if (c == 48) button[2] = 1'b1;
    end
  endtask

  task automatic test_mode_switch();
    exp_t e, got;
    mode = 6'b100101;
    for (int c = 1; c <= 12; c++) begin
      e.pr = '0; e.pl = '0; e.led = '0;
      e.led[0] = (c >= 1 && c < 5) || (c >= 9);
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL mode_switch c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
      if (c == 4) mode = 6'b100111;
      if (c == 8) mode = 6'b100101;
    end
  endtask

  task automatic test_async_reset();
    exp_t e, got;
    button[1] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      e.pr = '0; e.pl = '0; e.led = '0;
      e.pr[1]  = (c >= 6);
      e.pl[1]  = (c == 6);
      e.led[1] = (c >= 8);
      e.led[0] = 1'b1;
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL async_pre c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
      if (c == 10) button[0] = 1'b0;
    end
    // Mid-debounce on channel 0, LEDs lit: reset must clear without an edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pressed, press, led} !== 9'b0) begin
      failures++;
      $display("FAIL async_immediate got pr=%b pl=%b led=%b exp all 0", pressed, press, led);
    end
    for (int c = 1; c <= 2; c++) begin
      e.pr = '0; e.pl = '0; e.led = '0;
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL async_hold c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
    end
    rst_n = 1'b1;
    cyc   = 0;
    // Both buttons still held: simultaneous re-acceptance on two channels.
    for (int c = 1; c <= 10; c++) begin
      e.pr  = (c >= 6) ? 3'b011 : 3'b000;
      e.pl  = (c == 6) ? 3'b011 : 3'b000;
      e.led = (c >= 8) ? 3'b011 : 3'b000;
      sb.push_back(e);
      step();
      got = sb.pop_front();
      checks++;
      if ({pressed, press, led} !== {got.pr, got.pl, got.led}) begin
        failures++;
        $display("FAIL async_post c=%0d got pr=%b pl=%b led=%b exp pr=%b pl=%b led=%b",
                 c, pressed, press, led, got.pr, got.pl, got.led);
      end
    end
    button = 3'b111;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_follow();
    test_bounce();
    test_toggle();
    test_blink();
    test_mode_switch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
